dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised, handshaked data memory for the pipeline MEM stage.
- Generalises the earlier fixed 2048-word negedge-write, combinational-read data memory in four ways:
  - configurable depth;
  - configurable registered read latency;
  - valid/ready request interface with a response strobe;
  - little-endian byte-lane stores and sign/zero-extended sub-word loads, with an error response.
- Sits between the MEM-stage load/store unit and the register writeback path.

Parameters:
- ADDR_W, 13: byte-address width. Memory depth is 2**(ADDR_W-2) 32-bit words.
- READ_LAT, 1: cycles from load accept to response. Legal range 1..7.
- INIT_ZERO, 1: 1 = array zero-filled at elaboration (initial block). The array is never cleared by reset.

Ports:
- clk, input, 1: rising-edge clock; all state updates on posedge.
- rst_n, input, 1: reset, asynchronous assert, active low.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request this cycle.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned, input, 1: load extension; 1 = zero-extend, 0 = sign-extend.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, 32: store data, right-justified.
- rsp_valid, output, 1: one-cycle response strobe.
- rsp_data, output, 32: extended load data; 0 for stores and errors.
- rsp_err, output, 1: request rejected; qualified by rsp_valid.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=1, state=IDLE, counter=0. Memory contents are untouched by reset.
- Accept: req_valid && req_ready at a posedge. req_ready = (state==IDLE), combinational from state only.
- States and transitions:
  - IDLE, on store accept -> RESP.
  - IDLE, on load accept -> RESP if READ_LAT==1, else WAIT with counter = READ_LAT-1.
  - WAIT: counter decrements; at counter==1 -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
- No backpressure on the response.
- Latency from accept edge N:
  - store: rsp_valid is high in the cycle after edge N+1;
  - load: rsp_valid is high in the cycle after edge N+READ_LAT.
- Throughput: a store occupies 2 cycles; a load occupies READ_LAT+1 cycles. The next accept is possible in the cycle after RESP.
- Word index = req_addr[ADDR_W-1:2].
- Store write lanes (write occurs at the accept edge):
  - byte: lane req_addr[1:0] <= wdata[7:0];
  - half: lane pair req_addr[1] <= wdata[15:0];
  - word: all four lanes.
  - Lanes not selected keep their previous value.
- Load: the word is captured at the accept edge into a holding register, so a later write cannot alter an in-flight load. The selected byte or half is extracted by addr[1:0] / addr[1], then extended per req_unsigned.
- Ordering: a store followed by a load to the same word returns the new data.
- Errors: size=11 gives rsp_err=1, rsp_data=0, no write, store-style 2-cycle timing. For misaligned accesses, see Optional Feature.
- Registered request fields (size, lane bits, unsigned) are latched at accept and held until RESP.
- Reset mid-operation: the FSM returns to IDLE immediately and the pending response is dropped. A store write already committed at its accept edge persists.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, is rejected: rsp_err=1, no write, rsp_data=0, 2-cycle timing.
- Undefined: the offending low address bits are forced to 0 (half -> addr[0]=0; word -> addr[1:0]=00), the access is performed aligned, and rsp_err=0.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum IDLE/WAIT/RESP;
  - function lane_mask(size, addr[1:0]) -> 4-bit byte-enable.
- One sub-module: dmem_load_align. It is combinational and takes word, addr[1:0], size and unsigned, producing the extended 32-bit result.

Test Plan:
- Store word 0xDEADBEEF at 0x010, then load word at 0x010 -> rsp_data=0xDEADBEEF, rsp_err=0. With READ_LAT=3, rsp_valid rises exactly 3 edges after the load accept.
- Store byte 0x80 at 0x013 over 0x11223344, then load byte signed at 0x013 -> 0xFFFFFF80. Load byte unsigned at 0x013 -> 0x00000080. Load word at 0x010 -> 0x80223344.
- Store half 0xA5A5 at 0x022 over word 0 -> word 0xA5A50000. Load half signed at 0x022 -> 0xFFFFA5A5.
- Load word at 0x011:
  - with the macro defined -> rsp_err=1, rsp_data=0;
  - without the macro -> data of word 0x010, rsp_err=0.
- Send size=11 store at 0x030 -> rsp_err=1 and word 0x030 is unchanged.
- Hold req_valid high back-to-back -> req_ready=0 throughout WAIT/RESP and no second accept occurs. Assert rst_n=0 during WAIT -> rsp_valid never pulses, req_ready=1 after reset, and memory contents are preserved.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, FSM states and byte-lane masks.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte enables for a store; low address bits a size cannot use are ignored.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM-stage load/store unit and dmem_ctrl.
interface dmem_ctrl_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// Load data alignment: selects the byte/half/word from a memory word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = '0;
        case (size)
            SZ_BYTE: data = {{24{byte_sel[7] & ~uns}}, byte_sel};
            SZ_HALF: data = {{16{half_sel[15] & ~uns}}, half_sel};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data memory with byte-lane stores, extended sub-word loads and READ_LAT-cycle responses.
// DMEM_MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of force-aligning them.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_ctrl_if.slave bus,
    output logic      busy
);
    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

    // Power-up image only; reset never clears the array.
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic              accept;
    logic              req_err;
    logic [ADDR_W-3:0] idx;
    logic [1:0]        lo;
    logic [1:0]        lane_fix;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;

    logic [31:0] hold_word;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_err;
    logic        r_we;
    logic [31:0] ld_data;

    assign idx    = bus.req_addr[ADDR_W-1:2];
    assign lo     = bus.req_addr[1:0];
    assign accept = bus.req_valid && bus.req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (bus.req_size == SZ_HALF && lo[0]) || (bus.req_size == SZ_WORD && lo != 2'b00);
    assign req_err  = (bus.req_size == 2'b11) || misalign;
`else
    assign req_err  = (bus.req_size == 2'b11);
`endif

    // Forcing the unusable low bits to zero makes a misaligned access behave aligned.
    assign lane_fix  = (bus.req_size == SZ_WORD) ? 2'b00 :
                       (bus.req_size == SZ_HALF) ? {lo[1], 1'b0} : lo;
    assign be        = lane_mask(bus.req_size, lo);
    assign wdata_rep = (bus.req_size == SZ_BYTE) ? {4{bus.req_wdata[7:0]}} :
                       (bus.req_size == SZ_HALF) ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_word <= '0;
            r_lane    <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
        end else if (accept) begin
            hold_word <= mem[idx];
            r_lane    <= lane_fix;
            r_size    <= bus.req_size;
            r_uns     <= bus.req_unsigned;
            r_err     <= req_err;
            r_we      <= bus.req_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_we || req_err || READ_LAT == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 3'(READ_LAT - 1);
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    dmem_load_align u_align (
        .word    (hold_word),
        .addr_lo (r_lane),
        .size    (r_size),
        .uns     (r_uns),
        .data    (ld_data)
    );

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = (state == RESP) && r_err;
    assign bus.rsp_data  = ((state == RESP) && !r_we && !r_err) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with READ_LAT=3; honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_acc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] model [int];

    dmem_ctrl_if #(.ADDR_W(13)) bus ();

    dmem_ctrl #(.ADDR_W(13), .READ_LAT(LAT), .INIT_ZERO(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) n_acc <= n_acc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responses are popped in order; any pulse with nothing outstanding is a failure.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", bus.rsp_data, mon_e.d);
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.e});
                check("rsp_lat", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [12:0] addr, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [12:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int lat);
        exp_t e;
        @(negedge clk);
        drive(we, sz, uns, addr, wd);
        @(posedge clk);
        #1;
        e.d = exp_d; e.e = exp_e; e.due = cyc + lat - 1;
        sb.push_back(e);
        bus.req_valid = 1'b0;
        wait_done();
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return u ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    initial begin
        logic [31:0] w, d;
        logic [1:0]  sz, lo;
        logic        we, u;
        int          wi, acc0;

        bus.req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;

        send(1, SZ_WORD, 0, 13'h010, 32'hDEADBEEF, 32'h0, 0, 1);
        send(0, SZ_WORD, 0, 13'h010, 32'h0, 32'hDEADBEEF, 0, LAT);

        send(1, SZ_WORD, 0, 13'h010, 32'h11223344, 32'h0, 0, 1);
        send(1, SZ_BYTE, 0, 13'h013, 32'h00000080, 32'h0, 0, 1);
        send(0, SZ_BYTE, 0, 13'h013, 32'h0, 32'hFFFFFF80, 0, LAT);
        send(0, SZ_BYTE, 1, 13'h013, 32'h0, 32'h00000080, 0, LAT);
        send(0, SZ_WORD, 0, 13'h010, 32'h0, 32'h80223344, 0, LAT);
        send(0, SZ_BYTE, 0, 13'h011, 32'h0, 32'h00000033, 0, LAT);

        send(1, SZ_WORD, 0, 13'h020, 32'h0, 32'h0, 0, 1);
        send(1, SZ_HALF, 0, 13'h022, 32'h0000A5A5, 32'h0, 0, 1);
        send(0, SZ_WORD, 0, 13'h020, 32'h0, 32'hA5A50000, 0, LAT);
        send(0, SZ_HALF, 0, 13'h022, 32'h0, 32'hFFFFA5A5, 0, LAT);
        send(0, SZ_HALF, 1, 13'h020, 32'h0, 32'h00000000, 0, LAT);

`ifdef DMEM_MISALIGN_TRAP_EN
        send(0, SZ_WORD, 0, 13'h011, 32'h0, 32'h0, 1, 1);
        send(1, SZ_HALF, 0, 13'h021, 32'h00001234, 32'h0, 1, 1);
        send(0, SZ_WORD, 0, 13'h020, 32'h0, 32'hA5A50000, 0, LAT);
`else
        send(0, SZ_WORD, 0, 13'h011, 32'h0, 32'h80223344, 0, LAT);
        send(1, SZ_HALF, 0, 13'h021, 32'h00001234, 32'h0, 0, 1);
        send(0, SZ_WORD, 0, 13'h020, 32'h0, 32'hA5A51234, 0, LAT);
`endif

        send(1, SZ_WORD, 0, 13'h030, 32'h00000055, 32'h0, 0, 1);
        send(1, 2'b11, 0, 13'h030, 32'hFFFFFFFF, 32'h0, 1, 1);
        send(0, SZ_WORD, 0, 13'h030, 32'h0, 32'h00000055, 0, LAT);

        for (int i = 0; i < 40; i++) begin
            wi = $urandom_range(0, 7);
            sz = 2'($urandom_range(0, 2));
            lo = 2'($urandom_range(0, 3));
            if (sz == SZ_HALF) lo[0] = 1'b0;
            if (sz == SZ_WORD) lo = 2'b00;
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            d  = $urandom;
            w  = model.exists(wi) ? model[wi] : 32'h0;
            if (we) begin
                case (sz)
                    2'b00:   w[8*lo +: 8] = d[7:0];
                    2'b01:   w[16*lo[1] +: 16] = d[15:0];
                    default: w = d;
                endcase
                model[wi] = w;
                send(1, sz, u, 13'(13'h100 + wi * 4 + lo), d, 32'h0, 0, 1);
            end else begin
                send(0, sz, u, 13'(13'h100 + wi * 4 + lo), d, exp_load(w, lo, sz, u), 0, LAT);
            end
        end

        // Valid held through WAIT/RESP must not produce a second accept.
        @(negedge clk);
        acc0 = n_acc;
        drive(0, SZ_WORD, 0, 13'h010, 32'h0);
        @(posedge clk);
        #1;
        mon_e.d = 32'h80223344; mon_e.e = 1'b0; mon_e.due = cyc + LAT - 1;
        sb.push_back(mon_e);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("b2b_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        wait_done();
        @(posedge clk);
        #1;
        check("b2b_accepts", 32'(n_acc - acc0), 32'd1);

        // Reset during WAIT drops the pending load and preserves memory.
        send(1, SZ_WORD, 0, 13'h060, 32'hCAFEF00D, 32'h0, 0, 1);
        @(negedge clk);
        drive(0, SZ_WORD, 0, 13'h060, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(0, SZ_WORD, 0, 13'h060, 32'h0, 32'hCAFEF00D, 0, LAT);
        send(0, SZ_WORD, 0, 13'h030, 32'h0, 32'h00000055, 0, LAT);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
